// File: rtl/ntt_io_sequencer.sv
// ntt_io_sequencer: streams one polynomial into the banked coefficient memory, kicks the NTT core,
//   waits for its DONE, then streams the result back out in natural index order.
// Latency: load writes in the accept cycle; first output 2 cycles after entering UNLOAD; 1 beat/cycle.
// Backpressure: in_ready_o only in LOAD; out side is valid/ready with a 2-entry skid FIFO, reads throttled.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i                      begin a job (sampled in IDLE only)
//   in_valid_i/in_data_i/in_ready_o     input coefficient stream
//   mem_wr_en_o/mem_rd_en_o/mem_bank_o/mem_addr_o/mem_wdata_o/mem_rdata_i   banked memory port
//   mem_owner_core_o             1 while the core owns the memory (RUN)
//   core_start_o/core_done_i     core handshake
//   out_valid_o/out_data_o/out_ready_i  output coefficient stream
//   busy_o, job_done_o           status

// Small generic FIFO used as the read-data skid buffer. DEPTH must be a power of two >= 2.
// Latency: data pushed in cycle N is visible on pop_dat_o in cycle N+1.
// Backpressure: caller must not push when full unless popping in the same cycle.
module ntt_seq_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_vld_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_rdy_i,
  output logic             pop_vld_o,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full, push, pop;

  assign full      = (count_q == CW'(DEPTH));
  assign pop_vld_o = (count_q != '0);
  assign pop       = pop_vld_o && pop_rdy_i;
  assign push      = push_vld_i && (!full || pop);
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
                                  !(push_vld_i && full && !pop_rdy_i));
endmodule

module ntt_io_sequencer #(
  parameter int D_WIDTH = 17,
  parameter int BN      = 16,
  parameter int MA      = 64,
  parameter int AW      = $clog2(MA),
  parameter int BW      = $clog2(BN)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               in_valid_i,
  input  logic [D_WIDTH-1:0] in_data_i,
  output logic               in_ready_o,
  output logic [BN-1:0]      mem_wr_en_o,
  output logic               mem_rd_en_o,
  output logic [BW-1:0]      mem_bank_o,
  output logic [AW-1:0]      mem_addr_o,
  output logic [D_WIDTH-1:0] mem_wdata_o,
  input  logic [D_WIDTH-1:0] mem_rdata_i,
  output logic               mem_owner_core_o,
  output logic               core_start_o,
  input  logic               core_done_i,
  output logic               out_valid_o,
  output logic [D_WIDTH-1:0] out_data_o,
  input  logic               out_ready_i,
  output logic               busy_o,
  output logic               job_done_o
);
  localparam int DEGREE = BN * MA;
  localparam int LW     = BW + AW;
  localparam logic [LW-1:0] LAST_IDX = LW'(DEGREE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_UNLOAD = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] wr_idx_q, wr_idx_d;   // next coefficient to accept
  logic [LW-1:0] rd_idx_q, rd_idx_d;   // next coefficient to read from memory
  logic [LW-1:0] out_idx_q, out_idx_d; // next coefficient to hand downstream
  logic          rd_all_q, rd_all_d;   // every index has been read; stops rd_idx from wrapping
  logic          inflight_q;           // a read was issued last cycle, rdata valid now
  logic          started_q, started_d; // core_start already pulsed in this RUN visit

  logic          issue, accept, pop;
  logic          fifo_vld;
  logic [1:0]    fifo_cnt;
  logic [2:0]    pend_now, pend_after;

  ntt_seq_fifo #(
    .WIDTH (D_WIDTH),
    .DEPTH (2)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_vld_i (inflight_q),
    .push_dat_i (mem_rdata_i),
    .pop_rdy_i  (out_ready_i),
    .pop_vld_o  (fifo_vld),
    .pop_dat_o  (out_data_o),
    .count_o    (fifo_cnt)
  );

  assign out_valid_o = fifo_vld;
  assign pop         = fifo_vld && out_ready_i;
  assign busy_o      = (state_q != S_IDLE);
  assign accept      = (state_q == S_LOAD) && in_valid_i;

  // Reads buffered plus in flight, less the beat leaving this cycle. Counting the
  // departing beat lets a new read issue every cycle while the consumer keeps up,
  // yet never lets more than two beats be outstanding after this edge.
  assign pend_now   = {1'b0, fifo_cnt} + {2'b00, inflight_q};
  assign pend_after = pend_now - {2'b00, pop};

  always_comb begin
    state_d          = state_q;
    wr_idx_d         = wr_idx_q;
    rd_idx_d         = rd_idx_q;
    out_idx_d        = out_idx_q;
    rd_all_d         = rd_all_q;
    started_d        = 1'b0;
    issue            = 1'b0;
    in_ready_o       = 1'b0;
    mem_wr_en_o      = '0;
    mem_rd_en_o      = 1'b0;
    mem_bank_o       = '0;
    mem_addr_o       = '0;
    mem_wdata_o      = '0;
    mem_owner_core_o = 1'b0;
    core_start_o     = 1'b0;
    job_done_o       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        wr_idx_d  = '0;
        rd_idx_d  = '0;
        out_idx_d = '0;
        rd_all_d  = 1'b0;
        if (start_i) state_d = S_LOAD;
      end

      S_LOAD: begin
        in_ready_o = 1'b1;
        mem_bank_o = wr_idx_q[BW-1:0];
        mem_addr_o = wr_idx_q[LW-1:BW];
        if (accept) begin
          mem_wr_en_o = BN'(1) << wr_idx_q[BW-1:0];
          mem_wdata_o = in_data_i;
          if (wr_idx_q == LAST_IDX) state_d = S_RUN;
          else wr_idx_d = wr_idx_q + LW'(1);
        end
      end

      S_RUN: begin
        mem_owner_core_o = 1'b1;
        core_start_o     = !started_q;
        started_d        = 1'b1;
        if (core_done_i) state_d = S_UNLOAD;
      end

      S_UNLOAD: begin
        mem_bank_o  = rd_idx_q[BW-1:0];
        mem_addr_o  = rd_idx_q[LW-1:BW];
        issue       = !rd_all_q && (pend_after < 3'd2);
        mem_rd_en_o = issue;
        if (issue) begin
          if (rd_idx_q == LAST_IDX) rd_all_d = 1'b1;
          else rd_idx_d = rd_idx_q + LW'(1);
        end
        if (pop) begin
          if (out_idx_q == LAST_IDX) state_d = S_FINISH;
          else out_idx_d = out_idx_q + LW'(1);
        end
      end

      S_FINISH: begin
        job_done_o = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      out_idx_q  <= '0;
      rd_all_q   <= 1'b0;
      inflight_q <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      out_idx_q  <= out_idx_d;
      rd_all_q   <= rd_all_d;
      inflight_q <= issue;
      started_q  <= started_d;
    end
  end

  a_pending_bound: assert property (@(posedge clk_i) disable iff (rst_i) pend_now <= 3'd2);
  a_wr_onehot:     assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(mem_wr_en_o));
endmodule
